// File: rtl/vreg_bank_arbiter.sv
// Round-robin arbiter and sequencer for a shared bank of wide registers.
// Optional power-up clear of the bank: define VREG_BANK_ARB_INIT_EN.
module vreg_bank_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 56,
   localparam int IDW       = $clog2(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [NUM_REQ-1:0]               req,
   input  logic [NUM_REQ-1:0]               we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]    addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    wdata,
   output logic [NUM_REQ-1:0]               gnt,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             rvalid,
   output logic [IDW-1:0]                   rid,
   output logic                             init_done
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

`ifdef VREG_BANK_ARB_INIT_EN
   typedef enum logic [1:0] {S_INIT, S_IDLE, S_GRANT} state_t;
   localparam state_t RST_STATE = S_INIT;
`else
   typedef enum logic {S_IDLE, S_GRANT} state_t;
   localparam state_t RST_STATE = S_IDLE;
`endif

   state_t                  state_q, state_d;
   logic [IDW-1:0]          last_q, last_d;
   logic [IDW-1:0]          win_q, win_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wd_q, wd_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    rvalid_q, rvalid_d;
   logic [IDW-1:0]          rid_q, rid_d;
   logic                    init_done_q, init_done_d;
`ifdef VREG_BANK_ARB_INIT_EN
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
`endif

   logic [DATA_WIDTH-1:0]   bank_q [DEPTH];
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_wa;
   logic [DATA_WIDTH-1:0]   mem_wd;

   logic [IDW-1:0]          pick;
   logic                    found;

   // Round-robin search starting one past the last winner
   always_comb begin
      pick  = last_q;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int idx;
         idx = (int'(last_q) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = IDW'(idx);
         end
      end
   end

   // Next-state logic: init sweep, request capture, grant completion
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      win_d       = win_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wd_d        = wd_q;
      init_done_d = init_done_q;
`ifdef VREG_BANK_ARB_INIT_EN
      cnt_d       = cnt_q;
`else
      init_done_d = 1'b1;
`endif
      unique case (state_q)
`ifdef VREG_BANK_ARB_INIT_EN
         S_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d     = S_IDLE;
               init_done_d = 1'b1;
            end
         end
`endif
         S_IDLE: begin
            if (found) begin
               win_d   = pick;
               we_d    = we[pick];
               addr_d  = addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
               wd_d    = wdata[pick*DATA_WIDTH +: DATA_WIDTH];
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            last_d  = win_q;
            state_d = S_IDLE;
         end
         default: state_d = RST_STATE;
      endcase
   end

   // Read response captured on the closing edge of a read grant
   always_comb begin
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      rid_d    = rid_q;
      if (state_q == S_GRANT && !we_q) begin
         rdata_d  = bank_q[addr_q];
         rvalid_d = 1'b1;
         rid_d    = win_q;
      end
   end

   // Single bank write port shared by the clear sweep and granted writes
   always_comb begin
      mem_we = 1'b0;
      mem_wa = addr_q;
      mem_wd = wd_q;
`ifdef VREG_BANK_ARB_INIT_EN
      if (state_q == S_INIT) begin
         mem_we = 1'b1;
         mem_wa = cnt_q;
         mem_wd = '0;
      end
`endif
      if (state_q == S_GRANT && we_q) begin
         mem_we = 1'b1;
      end
   end

   // Grant is a decode of the registered winner, so reset kills it at once
   always_comb begin
      gnt = '0;
      if (state_q == S_GRANT) begin
         gnt[win_q] = 1'b1;
      end
   end

   // Control and response registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RST_STATE;
         last_q      <= IDW'(NUM_REQ - 1);
         win_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wd_q        <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         rid_q       <= '0;
         init_done_q <= 1'b0;
`ifdef VREG_BANK_ARB_INIT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         win_q       <= win_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wd_q        <= wd_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         rid_q       <= rid_d;
         init_done_q <= init_done_d;
`ifdef VREG_BANK_ARB_INIT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   // Bank storage, not reset; write enable is already gated by reset state
   always_ff @(posedge clk) begin
      if (mem_we) begin
         bank_q[mem_wa] <= mem_wd;
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign rid       = rid_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_vreg_bank_arbiter.sv
// Directed self-checking bench for vreg_bank_arbiter.
// Covers both builds of VREG_BANK_ARB_INIT_EN.
module tb_vreg_bank_arbiter;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [3:0]   req = '0;
   logic [3:0]   we = '0;
   logic [15:0]  addr = '0;
   logic [223:0] wdata = '0;
   logic [3:0]   gnt;
   logic [55:0]  rdata;
   logic         rvalid;
   logic [1:0]   rid;
   logic         init_done;

   int checks = 0;
   int errors = 0;

`ifdef VREG_BANK_ARB_INIT_EN
   localparam logic [3:0] HOLD = 4'b1111;
`else
   localparam logic [3:0] HOLD = 4'b0000;
`endif

   localparam logic [55:0] VAL5  = 56'h234567891200;
   localparam logic [55:0] VAL15 = 56'hDEADBEEF0F0F0F;

   vreg_bank_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .we        (we),
      .addr      (addr),
      .wdata     (wdata),
      .gnt       (gnt),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .rid       (rid),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".gnt"}, 64'(gnt), 64'h0);
      chk({tag, ".rvalid"}, 64'(rvalid), 64'h0);
      chk({tag, ".rdata"}, 64'(rdata), 64'h0);
      chk({tag, ".rid"}, 64'(rid), 64'h0);
      chk({tag, ".init_done"}, 64'(init_done), 64'h0);
   endtask

   // Releases reset away from the clock edge, then follows init
   task automatic release_and_init(input logic [3:0] hold);
      req = hold;
      reset_n = 1'b1;
`ifdef VREG_BANK_ARB_INIT_EN
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         chk($sformatf("init.gnt%0d", i), 64'(gnt), 64'h0);
         if (i == 15) chk("init.done15", 64'(init_done), 64'h0);
         if (i == 16) chk("init.done16", 64'(init_done), 64'h1);
      end
`else
      @(posedge clk); #1;
      chk("noinit.done1", 64'(init_done), 64'h1);
      chk("noinit.gnt1", 64'(gnt), 64'h0);
`endif
      req = '0;
   endtask

   // One access from a lone requester; DUT is idle on entry and exit
   task automatic access(input int r, input logic w, input logic [3:0] a,
                         input logic [55:0] d, input logic [55:0] exp,
                         input string tag);
      req = 4'(1 << r);
      we = w ? 4'(1 << r) : 4'h0;
      addr[r*4 +: 4] = a;
      wdata[r*56 +: 56] = d;
      @(posedge clk); #1;
      chk({tag, ".gnt"}, 64'(gnt), 64'(1 << r));
      req = '0;
      we = '0;
      @(posedge clk); #1;
      chk({tag, ".rvalid"}, 64'(rvalid), w ? 64'h0 : 64'h1);
      if (!w) begin
         chk({tag, ".rid"}, 64'(rid), 64'(r));
         chk({tag, ".rdata"}, 64'(rdata), 64'(exp));
      end
   endtask

   logic [3:0] rr_gnt [12];
   int         rr_rid [12];

   initial begin
      rr_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
      rr_rid = '{-1, 0, -1, 1, -1, 2, -1, 3, -1, 0, -1, 1};

      // Power-up reset
      #3;
      chk_zero("rst");
      repeat (2) @(posedge clk);
      #1;
      release_and_init(HOLD);

`ifdef VREG_BANK_ARB_INIT_EN
      // Every word cleared by the sweep
      for (int i = 0; i < 16; i++) begin
         access(i % 4, 1'b0, 4'(i), 56'h0, 56'h0,
                $sformatf("clr%0d", i));
      end
`endif

      // Single write then read from requester 2
      access(2, 1'b1, 4'd5, VAL5, 56'h0, "wr5");
      access(2, 1'b0, 4'd5, 56'h0, VAL5, "rd5");
      @(posedge clk); #1;
      chk("rd5.pulse", 64'(rvalid), 64'h0);
      chk("rd5.hold", 64'(rdata), 64'(VAL5));

      // Top address; requester 3 leaves last pointing at 3
      access(3, 1'b1, 4'd15, VAL15, 56'h0, "wr15");
      access(3, 1'b0, 4'd15, 56'h0, VAL15, "rd15");

      // Round-robin with all requesters holding reads
      for (int i = 0; i < 4; i++) addr[i*4 +: 4] = 4'(i);
      we = '0;
      req = 4'b1111;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk($sformatf("rr.gnt%0d", i), 64'(gnt), 64'(rr_gnt[i]));
         if (rr_rid[i] >= 0) begin
            chk($sformatf("rr.rv%0d", i), 64'(rvalid), 64'h1);
            chk($sformatf("rr.rid%0d", i), 64'(rid), 64'(rr_rid[i]));
         end
      end
      req = '0;

      // Same-address write and read arriving together; last is 1
      addr[3:0] = 4'd3;
      addr[7:4] = 4'd3;
      wdata[55:0] = 56'hA5;
      we = 4'b0001;
      req = 4'b0011;
      @(posedge clk); #1;
      chk("ord.gnt0", 64'(gnt), 64'h1);
      req[0] = 1'b0;
      we[0] = 1'b0;
      @(posedge clk); #1;
      chk("ord.gap", 64'(gnt), 64'h0);
      @(posedge clk); #1;
      chk("ord.gnt1", 64'(gnt), 64'h2);
      req = '0;
      @(posedge clk); #1;
      chk("ord.rv", 64'(rvalid), 64'h1);
      chk("ord.rid", 64'(rid), 64'h1);
      chk("ord.rdata", 64'(rdata), 64'hA5);

      // Reset asserted inside the grant cycle of a read
      addr[15:12] = 4'd5;
      req = 4'b1000;
      @(posedge clk); #1;
      chk("mid.gnt", 64'(gnt), 64'h8);
      #2;
      reset_n = 1'b0;
      req = '0;
      #1;
      chk_zero("mid");
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk($sformatf("mid.rv%0d", i), 64'(rvalid), 64'h0);
      end
      release_and_init(4'b0000);
      chk("mid.post_rv", 64'(rvalid), 64'h0);
`ifdef VREG_BANK_ARB_INIT_EN
      access(3, 1'b0, 4'd5, 56'h0, 56'h0, "reclr5");
`endif
      access(1, 1'b1, 4'd15, 56'h00C0FFEE123456, 56'h0, "wr15b");
      access(1, 1'b0, 4'd15, 56'h0, 56'h00C0FFEE123456, "rd15b");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vreg_bank_arbiter.md
# vreg_bank_arbiter

Round-robin arbiter and sequencer for a shared bank of wide registers. Several testbench-side or DUT-side requesters issue single read/write accesses to the bank. After reset the block clears the bank and asserts `init_done`. It then grants one requester at a time and returns read data with a valid pulse. It sits between the vreg access agents and the shared register storage, and serialises all accesses to it.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ADDR_WIDTH`, 4, word address width; bank depth is 2^ADDR_WIDTH
- `DATA_WIDTH`, 56, register word width
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `req` in NUM_REQ: per-requester access request, level
- `we` in NUM_REQ: per-requester write enable, qualified by `req`
- `addr` in NUM_REQ*ADDR_WIDTH: flattened addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- `wdata` in NUM_REQ*DATA_WIDTH: flattened write data, sliced the same way
- `gnt` out NUM_REQ: one-hot grant, one-cycle pulse
- `rdata` out DATA_WIDTH: read data
- `rvalid` out 1: read data valid, one-cycle pulse
- `rid` out $clog2(NUM_REQ): index of the requester the read data belongs to
- `init_done` out 1: bank initialised, accesses accepted

## Operation
- States: INIT, IDLE, GRANT.
- **INIT**
  - Internal counter walks addresses 0..DEPTH-1, writing 0 to one word per cycle.
  - After the word at DEPTH-1 is written: go to IDLE and set `init_done`=1.
  - `req` is ignored during INIT.
- **IDLE**
  - If any `req` bit is 1: pick the winner by round-robin starting at `last+1` (mod NUM_REQ), latch its index, `we`, `addr` and `wdata`, then go to GRANT.
  - If no `req` bit is 1: stay in IDLE.
- **GRANT**
  - `gnt[winner]`=1 for exactly this cycle.
  - If the latched `we`=1: the latched `wdata` is written to the latched `addr` on the closing edge.
  - If the latched `we`=0: the word is read and registered to `rdata`; `rvalid`=1 and `rid`=winner in the next cycle.
  - Set `last`=winner and return to IDLE.
- **Requester rule:** hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen, then drop `req` the next cycle. A `req` still high in IDLE after its grant is treated as a new access, at lowest priority.
- **Round-robin reset value:** `last`=NUM_REQ-1, so requester 0 has highest priority first.
- **Accesses to the same address:** an access sees all writes granted earlier, in grant order. A read granted directly after a write to the same address returns the new data.
- `init_done` stays 1 until the next reset.

## Timing
- **Reset values:** `gnt`=0, `rvalid`=0, `rdata`=0, `rid`=0, `init_done`=0, state=INIT, init counter=0. Bank contents are not reset directly.
- **Grant latency:** `req` sampled high in IDLE at edge N gives `gnt` high during cycle N+1.
- **Read latency:** `rdata`/`rvalid` valid during cycle N+2. `rdata` holds its value until the next read.
- **Throughput:** at most one access per 2 cycles. Back-to-back requests from different requesters are granted on alternating cycles.
- **Init duration:** with the init feature compiled in, `init_done` rises 2^ADDR_WIDTH cycles after `reset_n` deasserts.
- **Reset mid-operation:** `reset_n` low forces all outputs to their reset values immediately, without a clock edge.
  - A pending grant or read response is dropped.
  - A write in its GRANT cycle commits only if reset asserts after that cycle's closing edge.
  - The INIT sequence restarts from address 0.

## Configuration
- Macro: `VREG_BANK_ARB_INIT_EN`.
- **Defined:** INIT state as described. The bank is cleared to zero and `init_done` rises 2^ADDR_WIDTH cycles after reset release.
- **Undefined:**
  - No INIT state and no init counter.
  - Reset goes straight to IDLE, and `init_done`=1 from the first rising edge after reset release.
  - Bank contents are undefined (X) until written.

## Test plan
- **Init sweep** (macro defined): release reset, hold `req`=4'b1111 -> no `gnt` for 16 cycles. `init_done` rises at cycle 16 after release, and reads of addresses 0..15 return 56'h0.
- **Single write/read:** requester 2 writes 56'h234567891200 to addr 5, then reads addr 5 -> `gnt`=4'b0100 one cycle after `req`. `rdata`=56'h234567891200 with `rvalid`=1 and `rid`=2 two cycles after the read `req`.
- **Round-robin fairness:** all four requesters hold `req` continuously -> grants in order 0,1,2,3,0,1, each one cycle wide, spaced two cycles apart.
- **Same-address ordering:** requester 0 writes 56'hA5 to addr 3 and requester 1 reads addr 3 in the same cycle -> requester 0 granted first, and requester 1's read returns 56'hA5.
- **Reset mid-read:** assert `reset_n`=0 during the GRANT cycle of a read -> `rvalid` never pulses, all outputs are 0 immediately, and INIT restarts after release.
- **Macro undefined:** `init_done`=1 at the first edge after reset release, and a write then read to addr 15 returns the written value.
